// File: rtl/store_issue_ctrl.sv
// store_issue_ctrl: store-issue controller between MEM stage and the
// data-memory write port. Formats store data/strobes at enqueue, buffers
// stores in an in-order FIFO, issues them one at a time over
// req/gnt/bvalid, and reports load-after-store word-address hazards.
//
// Optional feature macro: STORE_MISALIGN_TRAP_EN
//   defined     : misaligned SH/SW are dropped and err_misalign pulses
//   not defined : low address bits below the access size are ignored
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | nothing in flight; leaves as soon as an entry is present
// REQ   | mem_req high, head entry driven, waiting for mem_gnt
// RESP  | granted, waiting for mem_bvalid to pop the head entry
module store_issue_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_bvalid,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic        busy,
  output logic        err_misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count, count_nxt;
  logic [29:0]   e_word [DEPTH];
  logic [31:0]   e_data [DEPTH];
  logic [3:0]    e_strb [DEPTH];
  logic [31:0]   fmt_data;
  logic [3:0]    fmt_strb;
  logic [AW-1:0] slot_off;
  logic          misalign, accept, push, pop;
  logic          unused_ld;

  // the two byte-offset bits never take part in the word-address compare
  assign unused_ld = ^ld_addr[1:0];

  assign st_ready = (count != CNT_FULL);
  assign accept   = st_valid && st_ready;

  // lane-align data and build strobes from address and size
  always_comb begin
    fmt_data = '0;
    fmt_strb = '0;
    case (st_size)
      2'd0: begin
        fmt_data = {24'd0, st_data[7:0]} << {st_addr[1:0], 3'b000};
        fmt_strb = 4'b0001 << st_addr[1:0];
      end
      2'd1: begin
        if (st_addr[1]) begin
          fmt_data = {st_data[15:0], 16'd0};
          fmt_strb = 4'b1100;
        end else begin
          fmt_data = {16'd0, st_data[15:0]};
          fmt_strb = 4'b0011;
        end
      end
      2'd2: begin
        fmt_data = st_data;
        fmt_strb = 4'b1111;
      end
      default: ;
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  assign misalign = ((st_size == 2'd1) && st_addr[0]) ||
                    ((st_size == 2'd2) && (st_addr[1:0] != 2'b00));

  // one-cycle error pulse for an accepted but dropped misaligned store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_misalign <= 1'b0;
    else        err_misalign <= accept && misalign;
  end
`else
  assign misalign     = 1'b0;
  assign err_misalign = 1'b0;
`endif

  // size 3 is accepted on the handshake but silently discarded
  assign push = accept && (st_size != 2'd3) && !misalign;
  assign pop  = (state == S_RESP) && mem_bvalid;

  // occupancy after this edge; full rules out push-while-full by construction
  always_comb begin
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // issue sequencing; looks at next occupancy so a fresh store issues next cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (count_nxt != '0) state_nxt = S_REQ;
      S_REQ:  if (mem_gnt) state_nxt = S_RESP;
      S_RESP: if (pop) state_nxt = (count_nxt != '0) ? S_REQ : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // control state: FSM, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
    end
  end

  // entry payload; only read while valid so it needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      e_word[tail] <= st_addr[31:2];
      e_data[tail] <= fmt_data;
      e_strb[tail] <= fmt_strb;
    end
  end

  assign mem_req   = (state == S_REQ);
  assign mem_addr  = mem_req ? {e_word[head], 2'b00} : '0;
  assign mem_wdata = mem_req ? e_data[head] : '0;
  assign mem_wstrb = mem_req ? e_strb[head] : '0;
  assign busy      = (count != '0) || (state != S_IDLE);

  // hazard: any occupied slot (head included while in flight) matching the load word
  always_comb begin
    ld_hit   = 1'b0;
    slot_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = AW'(i) - head;
      if (({1'b0, slot_off} < count) && (e_word[i] == ld_addr[31:2]))
        ld_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_issue_ctrl.sv
// Testbench for store_issue_ctrl: directed scenarios plus a randomized run
// checked against a queue-based reference model. Built with or without
// STORE_MISALIGN_TRAP_EN, matching the design build.
module tb_store_issue_ctrl;

  localparam int DEPTH = 2;
`ifdef STORE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [29:0] w;
    logic [31:0] d;
    logic [3:0]  s;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_size;
  logic        mem_req, mem_gnt, mem_bvalid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] ld_addr;
  logic        ld_hit, busy, err_misalign;

  int checks   = 0;
  int failures = 0;

  store_issue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_size(st_size), .st_data(st_data),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_bvalid(mem_bvalid),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .busy(busy), .err_misalign(err_misalign)
  );

  always #5 clk = ~clk;

  // advance one clock; land 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    st_valid = 1'b0; st_addr = '0; st_size = '0; st_data = '0;
    mem_gnt = 1'b0; mem_bvalid = 1'b0;
  endtask

  // reference formatting: byte-by-byte placement from access size and offset
  function automatic entry_t fmt(input logic [31:0] a, input logic [1:0] sz,
                                 input logic [31:0] d);
    entry_t e;
    int n, base;
    n = 1 << sz;
    base = (int'(a % 4) / n) * n;
    e.w = a[31:2];
    e.d = '0;
    e.s = '0;
    for (int b = 0; b < 4; b++) begin
      if (b >= base && b < base + n) begin
        e.s[b] = 1'b1;
        e.d[8*b +: 8] = d[8*(b-base) +: 8];
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    ld_addr = '0;
    step();
    checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL reset_st_ready got=%b exp=1", st_ready); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if (mem_wstrb !== 4'h0) begin failures++; $display("FAIL reset_mem_wstrb got=%b exp=0", mem_wstrb); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (err_misalign !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_misalign); end
    checks++; if (ld_hit !== 1'b0) begin failures++; $display("FAIL reset_ld_hit got=%b exp=0", ld_hit); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_sb_format();
    st_valid = 1'b1; st_addr = 32'h1003; st_size = 2'd0; st_data = 32'h0000_00AB;
    step();
    st_valid = 1'b0;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL sb_req got=%b exp=1", mem_req); end
    checks++; if (mem_addr !== 32'h1000) begin failures++; $display("FAIL sb_addr got=%h exp=00001000", mem_addr); end
    checks++; if (mem_wdata !== 32'hAB00_0000) begin failures++; $display("FAIL sb_wdata got=%h exp=ab000000", mem_wdata); end
    checks++; if (mem_wstrb !== 4'b1000) begin failures++; $display("FAIL sb_wstrb got=%b exp=1000", mem_wstrb); end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL sb_req_after_gnt got=%b exp=0", mem_req); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sb_busy_resp got=%b exp=1", busy); end
    mem_bvalid = 1'b1;
    step();
    mem_bvalid = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sb_busy_done got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    st_valid = 1'b1; st_size = 2'd2; st_addr = 32'h0000_A000; st_data = 32'h1111_1111;
    step();
    checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%b exp=1", st_ready); end
    checks++; if (mem_addr !== 32'h0000_A000) begin failures++; $display("FAIL b2b_first_addr got=%h exp=0000a000", mem_addr); end
    st_addr = 32'h0000_A004; st_data = 32'h2222_2222;
    step();
    st_addr = 32'h0000_A008; st_data = 32'h3333_3333;
    checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL b2b_full got=%b exp=0", st_ready); end
    step();
    checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_hold got=%b exp=0", st_ready); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_A000 || mem_wdata !== 32'h1111_1111)
      begin failures++; $display("FAIL b2b_req_stable got=%b/%h/%h exp=1/0000a000/11111111", mem_req, mem_addr, mem_wdata); end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    checks++; if (st_ready !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL b2b_resp got=%b/%b exp=0/0", st_ready, mem_req); end
    mem_bvalid = 1'b1;
    step();
    mem_bvalid = 1'b0;
    checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_pop got=%b exp=1", st_ready); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_A004 || mem_wdata !== 32'h2222_2222)
      begin failures++; $display("FAIL b2b_second got=%b/%h/%h exp=1/0000a004/22222222", mem_req, mem_addr, mem_wdata); end
    step();
    st_valid = 1'b0;
    checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL b2b_third_taken got=%b exp=0", st_ready); end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_bvalid = 1'b1;
    step();
    mem_bvalid = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_A008 || mem_wdata !== 32'h3333_3333 || mem_wstrb !== 4'hF)
      begin failures++; $display("FAIL b2b_third got=%b/%h/%h/%b exp=1/0000a008/33333333/1111", mem_req, mem_addr, mem_wdata, mem_wstrb); end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_bvalid = 1'b1;
    step();
    mem_bvalid = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", busy); end
  endtask

  task automatic test_ld_hit();
    ld_addr = 32'h2000;
    st_valid = 1'b1; st_addr = 32'h2002; st_size = 2'd1; st_data = 32'h0000_1234;
    #1;
    checks++; if (ld_hit !== 1'b0) begin failures++; $display("FAIL hit_before_enq got=%b exp=0", ld_hit); end
    step();
    st_valid = 1'b0;
    checks++; if (ld_hit !== 1'b1) begin failures++; $display("FAIL hit_req got=%b exp=1", ld_hit); end
    checks++; if (mem_wdata !== 32'h1234_0000 || mem_wstrb !== 4'b1100)
      begin failures++; $display("FAIL sh_format got=%h/%b exp=12340000/1100", mem_wdata, mem_wstrb); end
    ld_addr = 32'h2004;
    #1;
    checks++; if (ld_hit !== 1'b0) begin failures++; $display("FAIL hit_other_word got=%b exp=0", ld_hit); end
    ld_addr = 32'h2003;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    checks++; if (ld_hit !== 1'b1) begin failures++; $display("FAIL hit_resp got=%b exp=1", ld_hit); end
    step();
    checks++; if (ld_hit !== 1'b1) begin failures++; $display("FAIL hit_resp_wait got=%b exp=1", ld_hit); end
    mem_bvalid = 1'b1;
    step();
    mem_bvalid = 1'b0;
    checks++; if (ld_hit !== 1'b0) begin failures++; $display("FAIL hit_after_pop got=%b exp=0", ld_hit); end
  endtask

  task automatic test_invalid_size();
    st_valid = 1'b1; st_addr = 32'h3000; st_size = 2'd3; st_data = 32'hFFFF_FFFF;
    #1;
    checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL inv_ready got=%b exp=1", st_ready); end
    step();
    st_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || err_misalign !== 1'b0)
        begin failures++; $display("FAIL inv_discard got=%b/%b/%b exp=0/0/0", mem_req, busy, err_misalign); end
      step();
    end
  endtask

  task automatic test_misalign();
    st_valid = 1'b1; st_addr = 32'h4001; st_size = 2'd2; st_data = 32'hDEAD_BEEF;
    step();
    st_valid = 1'b0;
    if (TRAP) begin
      checks++; if (err_misalign !== 1'b1 || mem_req !== 1'b0)
        begin failures++; $display("FAIL mis_trap got=%b/%b exp=1/0", err_misalign, mem_req); end
      step();
      checks++; if (err_misalign !== 1'b0 || busy !== 1'b0)
        begin failures++; $display("FAIL mis_trap_once got=%b/%b exp=0/0", err_misalign, busy); end
    end else begin
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4000 || mem_wstrb !== 4'hF || mem_wdata !== 32'hDEAD_BEEF)
        begin failures++; $display("FAIL mis_pass got=%b/%h/%b/%h exp=1/00004000/1111/deadbeef", mem_req, mem_addr, mem_wstrb, mem_wdata); end
      checks++; if (err_misalign !== 1'b0) begin failures++; $display("FAIL mis_err_tied got=%b exp=0", err_misalign); end
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0; mem_bvalid = 1'b1;
      step();
      mem_bvalid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    ld_addr = 32'h6000;
    st_valid = 1'b1; st_addr = 32'h6000; st_size = 2'd2; st_data = 32'h5555_AAAA;
    step();
    st_valid = 1'b0;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rmid_req got=%b exp=1", mem_req); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || st_ready !== 1'b1 || busy !== 1'b0 || ld_hit !== 1'b0)
      begin failures++; $display("FAIL rmid_async got=%b/%b/%b/%b exp=0/1/0/0", mem_req, st_ready, busy, ld_hit); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0)
      begin failures++; $display("FAIL rmid_fields got=%h/%h/%b exp=0/0/0", mem_addr, mem_wdata, mem_wstrb); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL rmid_release got=%b/%b exp=0/0", busy, mem_req); end
  endtask

  task automatic test_random();
    entry_t q[$];
    entry_t e;
    bit in_resp, exp_err, exp_hit, exp_req, acc, mis, gnt_taken, popm;
    int n;
    in_resp = 1'b0;
    exp_err = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (q.size() > 0 && $urandom_range(1, 0) == 1)
        ld_addr = {q[$urandom_range(q.size() - 1, 0)].w, 2'($urandom)};
      else
        ld_addr = 32'h5000 + $urandom_range(63, 0);
      #1;
      exp_hit = 1'b0;
      foreach (q[k]) if (q[k].w == ld_addr[31:2]) exp_hit = 1'b1;
      exp_req = !in_resp && (q.size() > 0);
      checks++; if (st_ready !== (q.size() < DEPTH)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, st_ready, q.size() < DEPTH); end
      checks++; if (mem_req !== exp_req) begin failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, mem_req, exp_req); end
      checks++; if (busy !== (q.size() > 0)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, q.size() > 0); end
      checks++; if (ld_hit !== exp_hit) begin failures++; $display("FAIL rnd_hit cyc=%0d got=%b exp=%b", cyc, ld_hit, exp_hit); end
      checks++; if (err_misalign !== exp_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, err_misalign, exp_err); end
      if (exp_req) begin
        checks++;
        if (mem_addr !== {q[0].w, 2'b00} || mem_wdata !== q[0].d || mem_wstrb !== q[0].s) begin
          failures++;
          $display("FAIL rnd_issue cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, mem_addr, mem_wdata, mem_wstrb, {q[0].w, 2'b00}, q[0].d, q[0].s);
        end
      end
      st_valid   = ($urandom_range(2, 0) != 0);
      st_addr    = 32'h5000 + $urandom_range(63, 0);
      st_size    = 2'($urandom_range(3, 0));
      st_data    = $urandom;
      mem_gnt    = ($urandom_range(1, 0) == 1);
      mem_bvalid = ($urandom_range(1, 0) == 1);
      n = 1 << st_size;
      acc = st_valid && (q.size() < DEPTH);
      mis = (st_size != 2'd3) && ((st_addr % n) != 0);
      gnt_taken = !in_resp && (q.size() > 0) && mem_gnt;
      popm = in_resp && mem_bvalid;
      exp_err = TRAP && acc && mis;
      if (popm) begin
        void'(q.pop_front());
        in_resp = 1'b0;
      end
      if (gnt_taken) in_resp = 1'b1;
      if (acc && st_size != 2'd3 && !(TRAP && mis)) begin
        e = fmt(st_addr, st_size, st_data);
        q.push_back(e);
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sb_format();
    test_back_to_back();
    test_ld_hit();
    test_invalid_size();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_issue_ctrl.md
# store_issue_ctrl

Store-issue controller between the MEM stage and the data-memory write port. Accepts store requests from the CPU, formats data and byte strobes from address and size, holds them in a small in-order buffer, and issues them one at a time over a request/grant/response handshake. Also flags load-after-store hazards so the pipeline can stall until a matching store has drained.

## Interface
Parameters:
- DEPTH, 2: store buffer entries; power of two, 2..8.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- st_valid  input  1  store request from MEM stage.
- st_ready  output  1  buffer can accept; equals !full.
- st_addr  input  32  byte address.
- st_size  input  2  0=SB, 1=SH, 2=SW, 3=invalid.
- st_data  input  32  unaligned store data; low bytes significant.
- mem_req  output  1  write request to data memory.
- mem_gnt  input  1  memory accepted the request.
- mem_addr  output  32  word address, bits [1:0] forced to 0.
- mem_wdata  output  32  lane-aligned write data.
- mem_wstrb  output  4  byte strobes.
- mem_bvalid  input  1  write-complete response.
- ld_addr  input  32  address of the load currently in MEM.
- ld_hit  output  1  combinational: some valid entry, or the in-flight store, has the same word address (bits [31:2]) as ld_addr.
- busy  output  1  buffer non-empty or FSM not IDLE.
- err_misalign  output  1  one-cycle pulse on a rejected misaligned store; tied 0 when the feature is compiled out.

## Operation
- Enqueue on st_valid && st_ready. Formatting happens at enqueue:
  - SB: byte placed at lane addr[1:0], other lanes 0; wstrb = 1 << addr[1:0].
  - SH: halfword at lane addr[1]; wstrb 0011 or 1100.
  - SW: data unchanged; wstrb 1111.
- Size 3 completes the handshake but is discarded; it is not enqueued and raises no error.
- The buffer is an in-order FIFO with head/tail pointers wrapping at DEPTH, plus a count of 0..DEPTH.
- FSM states:
  - IDLE: go to REQ when count > 0.
  - REQ: mem_req = 1, head fields driven. mem_gnt moves to RESP.
  - RESP: mem_req = 0. mem_bvalid pops the head, then goes to REQ if count after the pop is > 0, otherwise IDLE.
- The head entry is not popped until mem_bvalid arrives, so ld_hit covers the in-flight store.
- mem_bvalid is ignored outside RESP. mem_gnt is ignored outside REQ.
- Enqueue while full is not possible, because st_ready = 0 even in the cycle a pop occurs. Enqueue and pop in the same cycle (not full) are allowed, and count is unchanged.

## Timing
- Reset values: st_ready = 1, mem_req = 0, mem_addr = 0, mem_wdata = 0, mem_wstrb = 0, busy = 0, err_misalign = 0, ld_hit = 0; FSM = IDLE; count = 0; pointers = 0.
- Latency:
  - Store enqueued at edge N into an empty, idle block gives mem_req = 1 in cycle N+1.
  - mem_gnt sampled at edge M gives mem_req = 0 in cycle M+1.
  - mem_bvalid at edge K pops the entry. With a further entry pending, mem_req = 1 again in cycle K+1.
- mem_req, once asserted, stays high with stable mem_addr/mem_wdata/mem_wstrb until mem_gnt is sampled high.
- ld_hit is pure combinational from ld_addr and buffer state, with no cycle delay. An entry enqueued at edge N is visible in ld_hit from cycle N+1.
- Reset asserted mid-transaction immediately clears all state and outputs; pending stores are lost.

## Configuration
- STORE_MISALIGN_TRAP_EN defined: an SH with addr[0] = 1, or an SW with addr[1:0] != 0, completes the handshake but is not enqueued. err_misalign pulses high for exactly the cycle after acceptance.
- Not defined: misaligned stores are enqueued with the low address bits ignored. SH uses addr[1] only; SW uses lane 0, wstrb 1111. err_misalign is tied 0.

## Test plan
- Reset release, then SB at addr 0x1003 with data 0x000000AB: next cycle mem_req = 1, mem_addr = 0x1000, mem_wdata = 0xAB000000, mem_wstrb = 1000.
- DEPTH = 2, hold mem_gnt = 0, issue 3 back-to-back SW stores: the first two are accepted, st_ready = 0 on the third until the first mem_bvalid pop. Issue order to memory = enqueue order.
- SH at 0x2002 with data 0x1234 pending, ld_addr = 0x2000: ld_hit = 1. Hit stays 1 through REQ and RESP, and drops the cycle after mem_bvalid.
- st_size = 3 at 0x3000: accepted, count stays 0, mem_req never asserts, busy stays 0.
- SW at 0x4001:
  - With STORE_MISALIGN_TRAP_EN: err_misalign pulses once, nothing issued.
  - Without it: mem_addr = 0x4000, wstrb 1111.
- mem_req high in REQ, rst_n pulsed low for 1 cycle: all outputs return to reset values asynchronously and busy = 0 after release.
